fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the 128-word instruction memory for the MIPS datapath.
- Owns the program counter and drives the memory's byte address.
- Captures each returned word with its PC into a 2-entry buffer.
- Delivers entries to decode over a valid/ready handshake.
- Handles branch/jump redirects, stalls and out-of-range faults; sits between the instruction memory and the decode stage.

---
 rtl/fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC, 2-entry fetch buffer, redirect and fault.
// Optional FETCH_PERF_EN adds DeliveredCount / BubbleCount counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstruction,
  output logic [31:0] OutPC,
  output logic        Fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] DeliveredCount,
  output logic [31:0] BubbleCount
`endif
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic        fault;
  logic        fault_nx;

  logic [31:0] buf_pc  [2];
  logic [31:0] buf_ins [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        flush;
  logic        redir;
  logic        misaligned;
  logic        out_of_range;

  assign OutValid       = (count != 2'd0);
  assign OutPC          = OutValid ? buf_pc[rd_ptr]  : 32'h0;
  assign OutInstruction = OutValid ? buf_ins[rd_ptr] : 32'h0;
  assign IMemAddress    = pc;
  assign Fault          = fault;

  assign pop          = OutValid && OutReady;
  assign redir        = Redirect && (state != FAULT);
  assign misaligned   = (RedirectTarget[1:0] != 2'b00);
  assign out_of_range = (pc >= PC_LIMIT);

  // State, PC and fault registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      fault <= fault_nx;
    end
  end

  // Next state: redirect first, then fetch/fault sequencing
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    fault_nx = fault;
    push     = 1'b0;
    flush    = 1'b0;
    if (redir) begin
      flush = 1'b1;
      if (misaligned) begin
        fault_nx = 1'b1;
        state_nx = FAULT;
      end else begin
        pc_nx = RedirectTarget;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) state_nx = FETCH;
        end
        FETCH: begin
          if (out_of_range) begin
            fault_nx = 1'b1;
            state_nx = FAULT;
          end else if ((count < 2'd2) || pop) begin
            push  = 1'b1;
            pc_nx = pc + 32'd4;
          end
        end
        FAULT: begin
          state_nx = FAULT;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Two-entry fetch buffer; flush discards everything not yet popped
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      buf_pc[0]  <= 32'h0;
      buf_pc[1]  <= 32'h0;
      buf_ins[0] <= 32'h0;
      buf_ins[1] <= 32'h0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr]  <= pc;
        buf_ins[wr_ptr] <= IMemInstruction;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef FETCH_PERF_EN
  logic bubble;
  assign bubble = (state == FETCH) && OutReady && !OutValid;

  // Delivery and bubble counters, wrapping at 2^32
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DeliveredCount <= 32'h0;
      BubbleCount    <= 32'h0;
    end else begin
      if (pop)    DeliveredCount <= DeliveredCount + 32'd1;
      if (bubble) BubbleCount    <= BubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; memory word i holds i*3.
// Define FETCH_PERF_EN on both files to exercise the counters.
module tb_fetch_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstruction;
  logic [31:0] OutPC;
  logic        Fault;
`ifdef FETCH_PERF_EN
  logic [31:0] DeliveredCount;
  logic [31:0] BubbleCount;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] imem [128];

  fetch_sequencer dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Start          (Start),
    .IMemAddress    (IMemAddress),
    .IMemInstruction(IMemInstruction),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .OutValid       (OutValid),
    .OutReady       (OutReady),
    .OutInstruction (OutInstruction),
    .OutPC          (OutPC),
    .Fault          (Fault)
`ifdef FETCH_PERF_EN
    ,
    .DeliveredCount (DeliveredCount),
    .BubbleCount    (BubbleCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Combinational instruction memory
  always_comb begin
    IMemInstruction = 32'h0;
    if (IMemAddress < 32'd512) IMemInstruction = imem[IMemAddress[8:2]];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset          = 1'b1;
    Start          = 1'b0;
    Redirect       = 1'b0;
    RedirectTarget = 32'h0;
    OutReady       = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 32'(i * 3);

    // Reset values
    do_reset();
    check("rst_valid", {31'h0, OutValid}, 32'h0);
    check("rst_pc", OutPC, 32'h0);
    check("rst_ins", OutInstruction, 32'h0);
    check("rst_addr", IMemAddress, 32'h0);
    check("rst_fault", {31'h0, Fault}, 32'h0);

    // Start latency and streaming throughput
    Start    = 1'b1;
    OutReady = 1'b1;
    tick();
    Start = 1'b0;
    check("s1_valid", {31'h0, OutValid}, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("s_valid", {31'h0, OutValid}, 32'h1);
      check("s_pc", OutPC, 32'(i * 4));
      check("s_ins", OutInstruction, 32'(i * 3));
      tick();
    end

    // Backpressure: two entries, PC holds at 8
    do_reset();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    check("bp_first_pc", OutPC, 32'h0);
    repeat (4) tick();
    check("bp_addr", IMemAddress, 32'h8);
    check("bp_head", OutPC, 32'h0);
    OutReady = 1'b1;
    tick();
    check("bp_pc4", OutPC, 32'h4);
    tick();
    check("bp_pc8", OutPC, 32'h8);
    check("bp_ins8", OutInstruction, 32'd6);
    tick();
    check("bp_pc12", OutPC, 32'hc);

    // Redirect with a full buffer
    do_reset();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    Redirect       = 1'b1;
    RedirectTarget = 32'h40;
    tick();
    Redirect = 1'b0;
    check("rd_valid0", {31'h0, OutValid}, 32'h0);
    check("rd_addr", IMemAddress, 32'h40);
    tick();
    check("rd_valid1", {31'h0, OutValid}, 32'h1);
    check("rd_pc", OutPC, 32'h40);
    check("rd_ins", OutInstruction, 32'd48);
    OutReady = 1'b1;
    tick();
    check("rd_next", OutPC, 32'h44);

    // Run off the end of memory
    Redirect       = 1'b1;
    RedirectTarget = 32'h1f8;
    tick();
    Redirect = 1'b0;
    tick();
    check("end_pc0", OutPC, 32'h1f8);
    check("end_ins0", OutInstruction, 32'd378);
    tick();
    check("end_pc1", OutPC, 32'h1fc);
    check("end_ins1", OutInstruction, 32'd381);
    check("end_nofault", {31'h0, Fault}, 32'h0);
    tick();
    check("end_fault", {31'h0, Fault}, 32'h1);
    check("end_valid", {31'h0, OutValid}, 32'h0);
    Redirect       = 1'b1;
    RedirectTarget = 32'h0;
    tick();
    Redirect = 1'b0;
    tick();
    check("flt_addr", IMemAddress, 32'h200);
    check("flt_valid", {31'h0, OutValid}, 32'h0);
    check("flt_sticky", {31'h0, Fault}, 32'h1);

    // Misaligned redirect, then asynchronous reset
    do_reset();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    Redirect       = 1'b1;
    RedirectTarget = 32'h42;
    tick();
    Redirect = 1'b0;
    check("mis_fault", {31'h0, Fault}, 32'h1);
    check("mis_valid", {31'h0, OutValid}, 32'h0);
    check("mis_addr", IMemAddress, 32'h8);
    #2;
    Reset = 1'b1;
    #1;
    check("ar_fault", {31'h0, Fault}, 32'h0);
    check("ar_valid", {31'h0, OutValid}, 32'h0);
    check("ar_addr", IMemAddress, 32'h0);
    #2;
    Reset = 1'b0;

`ifdef FETCH_PERF_EN
    // Counters: 10 deliveries, 3 bubble cycles
    do_reset();
    Start    = 1'b1;
    OutReady = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("pf_a_pc", OutPC, 32'(i * 4));
      if (i == 3) Redirect = 1'b1;
      tick();
    end
    Redirect = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("pf_b_pc", OutPC, 32'(i * 4));
      if (i == 5) Redirect = 1'b1;
      tick();
    end
    Redirect = 1'b0;
    tick();
    OutReady = 1'b0;
    check("pf_deliv", DeliveredCount, 32'd10);
    check("pf_bubble", BubbleCount, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
